// File: rtl/bft_tx_arbiter_pkg.sv
// Shared types and defaults for the BFT upstream-port arbiter.
// Packet layout: bit PACKET_BITS-1 is the valid flag; the lower bits are payload.
package bft_tx_arbiter_pkg;

  localparam int PACKET_BITS_DEF = 49;
  localparam int NUM_SRC_DEF     = 4;
  localparam int BURST_LEN_DEF   = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bft_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after rr_last, wrapping.
module bft_tx_arbiter_rr_pick
  import bft_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int IDX_W   = width_of(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   rr_last,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan indices above rr_last first, then wrap to the ones at or below it.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!any && req[i] && (IDX_W'(i) > rr_last)) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end else begin
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!any && req[i] && (IDX_W'(i) <= rr_last)) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end else begin
      end
    end
  end

endmodule

// File: rtl/bft_tx_arbiter.sv
// Shares one BFT upstream port among NUM_SRC producers: round-robin grant,
// bounded bursts, one registered packet slot that holds while the BFT asserts resend.
module bft_tx_arbiter
  import bft_tx_arbiter_pkg::*;
#(
  parameter int PACKET_BITS = PACKET_BITS_DEF,
  parameter int NUM_SRC     = NUM_SRC_DEF,
  parameter int BURST_LEN   = BURST_LEN_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PACKET_BITS*NUM_SRC-1:0] din_src_pkt,
  input  logic [NUM_SRC-1:0]             vld_src2arb,
  output logic [NUM_SRC-1:0]             ack_arb2src,
  output logic [PACKET_BITS-1:0]         dout_leaf_interface2bft,
  input  logic                           resend,
  output logic [width_of(NUM_SRC)-1:0]   grant_id
);

  localparam int IDX_W   = width_of(NUM_SRC);
  localparam int CNT_W   = $clog2(BURST_LEN + 1);
  localparam int VLD_BIT = PACKET_BITS - 1;

  arb_state_e               state_r, state_n;
  logic [IDX_W-1:0]         owner_r, owner_n;
  logic [IDX_W-1:0]         rr_last_r, rr_last_n;
  logic [IDX_W-1:0]         grant_r, grant_n;
  logic [CNT_W-1:0]         beat_r, beat_n;
  logic [PACKET_BITS-1:0]   dout_r, dout_n;

  logic                     slot_free_s;
  logic [NUM_SRC-1:0]       ack_s;
  logic [NUM_SRC-1:0]       owner_oh_s;
  logic                     owner_vld_s;
  logic [NUM_SRC-1:0]       pick_gnt_s;
  logic [IDX_W-1:0]         pick_idx_s;
  logic                     pick_any_s;
  logic [PACKET_BITS-1:0]   pkt_sel_s;

  // resend only matters while the slot actually holds a packet
  assign slot_free_s = !dout_r[VLD_BIT] || !resend;

  bft_tx_arbiter_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (vld_src2arb),
    .rr_last (rr_last_r),
    .gnt     (pick_gnt_s),
    .idx     (pick_idx_s),
    .any     (pick_any_s)
  );

  // Decode the burst owner into a one-hot vector and test its request.
  always_comb begin
    owner_oh_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      owner_oh_s[i] = (owner_r == IDX_W'(i));
    end
    owner_vld_s = |(vld_src2arb & owner_oh_s);
  end

  // Next-state, ack and burst bookkeeping.
  always_comb begin
    state_n   = state_r;
    owner_n   = owner_r;
    rr_last_n = rr_last_r;
    grant_n   = grant_r;
    beat_n    = beat_r;
    ack_s     = '0;
    case (state_r)
      ST_IDLE: begin
        if (slot_free_s && pick_any_s) begin
          ack_s   = pick_gnt_s;
          owner_n = pick_idx_s;
          grant_n = pick_idx_s;
          beat_n  = CNT_W'(1);
          if (BURST_LEN == 1) begin
            rr_last_n = pick_idx_s;
            state_n   = ST_IDLE;
          end else begin
            state_n = ST_BURST;
          end
        end else begin
        end
      end
      ST_BURST: begin
        if (!slot_free_s) begin
        end else if (owner_vld_s) begin
          ack_s  = owner_oh_s;
          beat_n = beat_r + CNT_W'(1);
          if ((beat_r + CNT_W'(1)) == CNT_W'(BURST_LEN)) begin
            state_n   = ST_IDLE;
            rr_last_n = owner_r;
          end else begin
          end
        end else begin
          // owner went quiet: release the grant, leaving one empty cycle on dout
          state_n   = ST_IDLE;
          rr_last_n = owner_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Select the acked packet and compute the next output slot contents.
  always_comb begin
    pkt_sel_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack_s[i]) begin
        pkt_sel_s = din_src_pkt[i*PACKET_BITS +: PACKET_BITS];
      end else begin
      end
    end
    if (|ack_s) begin
      dout_n          = pkt_sel_s;
      dout_n[VLD_BIT] = 1'b1;
    end else if (slot_free_s) begin
      dout_n = '0;
    end else begin
      dout_n = dout_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      owner_r   <= '0;
      rr_last_r <= IDX_W'(NUM_SRC - 1);
      grant_r   <= '0;
      beat_r    <= '0;
      dout_r    <= '0;
    end else begin
      state_r   <= state_n;
      owner_r   <= owner_n;
      rr_last_r <= rr_last_n;
      grant_r   <= grant_n;
      beat_r    <= beat_n;
      dout_r    <= dout_n;
    end
  end

  // No packet is taken while reset is asserted, so no ack may be shown either.
  assign ack_arb2src             = reset ? '0 : ack_s;
  assign dout_leaf_interface2bft = dout_r;
  assign grant_id                = grant_r;

endmodule

// File: tb/tb_bft_tx_arbiter.sv
// Scoreboard bench for bft_tx_arbiter (NUM_SRC=3, BURST_LEN=2, PACKET_BITS=49).
module tb_bft_tx_arbiter;

  localparam int PB = 49;
  localparam int NS = 3;
  localparam int BL = 2;

  logic              clk;
  logic              reset;
  logic [PB*NS-1:0]  din_src_pkt;
  logic [NS-1:0]     vld_src2arb;
  logic [NS-1:0]     ack_arb2src;
  logic [PB-1:0]     dout_leaf_interface2bft;
  logic              resend;
  logic [1:0]        grant_id;

  bft_tx_arbiter #(.PACKET_BITS(PB), .NUM_SRC(NS), .BURST_LEN(BL)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_src_pkt             (din_src_pkt),
    .vld_src2arb             (vld_src2arb),
    .ack_arb2src             (ack_arb2src),
    .dout_leaf_interface2bft (dout_leaf_interface2bft),
    .resend                  (resend),
    .grant_id                (grant_id)
  );

  int checks = 0;
  int errors = 0;

  int rem[NS];
  int seq[NS];
  int exp_q[$];

  logic          pend_v = 1'b0;
  logic [PB-1:0] pend_pkt;
  int            pend_src;
  int            ms;

  logic [NS-1:0] ack_q;
  logic [PB-1:0] dout_q;
  logic [1:0]    gid_q;
  logic [PB-1:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PB-1:0] mk_pkt(input int src, input int s);
    logic [PB-1:0] p;
    p = {s[0], 16'(s * 7 + 3), 8'(src), 24'h5A0F00 | 24'(s)};
    return p;
  endfunction

  function automatic logic [PB-1:0] with_vld(input logic [PB-1:0] p);
    logic [PB-1:0] q;
    q = p;
    q[PB-1] = 1'b1;
    return q;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      vld_src2arb[i] = (rem[i] > 0);
      din_src_pkt[i*PB +: PB] = mk_pkt(i, seq[i]);
    end
  endtask

  // One cycle: sample outputs on the falling edge, advance producers after the rising edge.
  task automatic tick();
    @(negedge clk);
    ack_q  = ack_arb2src;
    dout_q = dout_leaf_interface2bft;
    gid_q  = grant_id;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (ack_q[i]) begin
        rem[i]--;
        seq[i]++;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    resend = 1'b0;
    for (int i = 0; i < NS; i++) rem[i] = 0;
    drive();
    tick();
    tick();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || pend_v) && c < 40) begin
      tick();
      c++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_src_done"}, 64'(rem[0] + rem[1] + rem[2]), 64'd0);
  endtask

  // Monitor: every ack pops the next expected owner; next cycle dout must carry its packet.
  always @(negedge clk) begin
    if (reset) begin
      pend_v = 1'b0;
    end else begin
      if (pend_v) begin
        chk("dout_pkt", 64'(dout_leaf_interface2bft), 64'(pend_pkt));
        chk("grant_id", 64'(grant_id), 64'(pend_src));
        pend_v = 1'b0;
      end
      if (ack_arb2src != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'(ack_arb2src), 64'd0);
        end else begin
          ms = exp_q.pop_front();
          chk("ack_order", 64'(ack_arb2src), 64'(3'b001 << ms));
          pend_pkt = with_vld(mk_pkt(ms, seq[ms]));
          pend_src = ms;
          pend_v   = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    resend      = 1'b0;
    din_src_pkt = '0;
    vld_src2arb = '0;
    for (int i = 0; i < NS; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end

    // 1: reset values, single packet from src0, then idle zero
    do_reset();
    tick();
    chk("rst_dout", 64'(dout_q), 64'd0);
    chk("rst_ack", 64'(ack_q), 64'd0);
    chk("rst_gid", 64'(gid_q), 64'd0);
    rem[0] = 1;
    drive();
    exp_q.push_back(0);
    tick();
    chk("t1_ack0", 64'(ack_q), 64'b001);
    tick();
    tick();
    chk("t1_idle_zero", 64'(dout_q), 64'd0);
    wait_drain("t1");

    // 2: all three requesting, bursts of two back to back
    do_reset();
    rem[0] = 4; rem[1] = 2; rem[2] = 2;
    drive();
    foreach (exp_q[i]) ;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
    exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(0);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("t2_no_gap", 64'(ack_q != '0), 64'd1);
    end
    wait_drain("t2");

    // 3: stall for three cycles in the middle of a src1 burst
    do_reset();
    rem[1] = 2; rem[2] = 1;
    drive();
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2);
    held = with_vld(mk_pkt(1, seq[1]));
    tick();
    resend = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_stall_ack", 64'(ack_q), 64'd0);
      chk("t3_stall_hold", 64'(dout_q), 64'(held));
    end
    resend = 1'b0;
    tick();
    chk("t3_resume_ack1", 64'(ack_q), 64'b010);
    wait_drain("t3");

    // 4: owner drops after one packet -> bubble, then src2
    do_reset();
    rem[0] = 1; rem[2] = 1;
    drive();
    exp_q.push_back(0); exp_q.push_back(2);
    tick();
    tick();
    chk("t4_bubble_ack", 64'(ack_q), 64'd0);
    tick();
    chk("t4_bubble_dout", 64'(dout_q), 64'd0);
    chk("t4_ack2", 64'(ack_q), 64'b100);
    wait_drain("t4");

    // 5: payload with MSB clear; resend while slot empty must not block
    do_reset();
    if (seq[0] % 2 != 0) seq[0]++;
    resend = 1'b1;
    rem[0] = 1;
    drive();
    exp_q.push_back(0);
    tick();
    chk("t5_ack_despite_resend", 64'(ack_q), 64'b001);
    resend = 1'b0;
    tick();
    chk("t5_msb_forced", 64'(dout_q[PB-1]), 64'd1);
    wait_drain("t5");

    // 6: reset during a stall drops the held packet; src1 wins again afterwards
    do_reset();
    rem[1] = 3; rem[2] = 2;
    drive();
    exp_q.push_back(1);
    tick();
    resend = 1'b1;
    tick();
    tick();
    chk("t6_stall_ack", 64'(ack_q), 64'd0);
    reset = 1'b1;
    tick();
    tick();
    chk("t6_rst_ack_gated", 64'(ack_q), 64'd0);
    chk("t6_rst_dout", 64'(dout_q), 64'd0);
    reset  = 1'b0;
    resend = 1'b0;
    exp_q.delete();
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(2);
    tick();
    chk("t6_post_dout", 64'(dout_q), 64'd0);
    chk("t6_post_ack1", 64'(ack_q), 64'b010);
    wait_drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
